// File: rtl/usb_fs_in_arb_pkg.sv
// Shared definitions for the USB full-speed IN endpoint arbiter: FSM encoding and packet limits.
package usb_fs_in_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FILL     = 2'd1,
        ST_WAIT_ACK = 2'd2
    } state_t;

    localparam int DEFAULT_MAX_PKT = 32;
    localparam int CNT_W           = 7;

endpackage

// File: rtl/usb_fs_in_arb_if.sv
// Signals between the arbiter, its clients and the IN engine; master is the arbiter's view.
interface usb_fs_in_arb_if #(
    parameter int NUM_CLIENTS = 4
);
    logic [NUM_CLIENTS-1:0]   client_req;
    logic [NUM_CLIENTS-1:0]   client_grant;
    logic [NUM_CLIENTS-1:0]   client_data_put;
    logic [8*NUM_CLIENTS-1:0] client_data;
    logic [NUM_CLIENTS-1:0]   client_data_done;
    logic [NUM_CLIENTS-1:0]   client_stall;
    logic                     client_free;
    logic [NUM_CLIENTS-1:0]   client_acked;
    logic                     ep_reset;
    logic                     in_ep_data_free;
    logic                     in_ep_data_put;
    logic [7:0]               in_ep_data;
    logic                     in_ep_data_done;
    logic                     in_ep_stall;
    logic                     in_ep_acked;

    modport master (
        input  client_req, client_data_put, client_data, client_data_done, client_stall,
        input  ep_reset, in_ep_data_free, in_ep_acked,
        output client_grant, client_free, client_acked,
        output in_ep_data_put, in_ep_data, in_ep_data_done, in_ep_stall
    );

    modport slave (
        output client_req, client_data_put, client_data, client_data_done, client_stall,
        output ep_reset, in_ep_data_free, in_ep_acked,
        input  client_grant, client_free, client_acked,
        input  in_ep_data_put, in_ep_data, in_ep_data_done, in_ep_stall
    );

endinterface

// File: rtl/usb_fs_in_arb_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after the pointer, wrapping.
module usb_rr_arbiter #(
    parameter int N    = 4,
    parameter int IDXW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    i_req,
    input  logic [IDXW-1:0] i_ptr,
    output logic [N-1:0]    o_grant,
    output logic [IDXW-1:0] o_idx,
    output logic            o_valid
);

    logic [IDXW-1:0] w_pos;

    // Scan outward from the pointer; the first hit wins.
    always_comb begin
        w_pos   = {IDXW{1'b0}};
        o_grant = {N{1'b0}};
        o_idx   = {IDXW{1'b0}};
        o_valid = 1'b0;
        for (int k = 0; k < N; k++) begin
            w_pos = IDXW'((int'(i_ptr) + k) % N);
            if (!o_valid && i_req[w_pos]) begin
                o_valid        = 1'b1;
                o_grant[w_pos] = 1'b1;
                o_idx          = w_pos;
            end else begin
                o_valid = o_valid;
            end
        end
    end

endmodule

// File: rtl/usb_fs_in_arb.sv
// Shares one USB IN endpoint among several clients: round-robin grant, byte
// forwarding with packet-size limit, and ack/stall/abort handling.
module usb_fs_in_arb
    import usb_fs_in_arb_pkg::*;
#(
    parameter int NUM_CLIENTS = 4,
    parameter int MAX_PKT     = DEFAULT_MAX_PKT
) (
    input  logic            clk,
    input  logic            reset,
    usb_fs_in_arb_if.master bus
);

    localparam int IDXW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_PKT);
    localparam logic [IDXW-1:0]  LAST_IDX = IDXW'(NUM_CLIENTS - 1);

    state_t                 r_state, w_state_nxt;
    logic [NUM_CLIENTS-1:0] r_grant, w_grant_nxt;
    logic [IDXW-1:0]        r_idx, w_idx_nxt;
    logic [IDXW-1:0]        r_rr_ptr, w_rr_nxt, w_next_ptr;
    logic [CNT_W-1:0]       r_count, w_count_nxt, w_count_inc;

    logic [NUM_CLIENTS-1:0] w_arb_grant;
    logic [IDXW-1:0]        w_arb_idx;
    logic                   w_arb_valid;

    logic w_fill, w_wait, w_put_g, w_done_g, w_stall_g, w_fwd;

    usb_rr_arbiter #(.N(NUM_CLIENTS), .IDXW(IDXW)) u_rr (
        .i_req   (bus.client_req),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_arb_grant),
        .o_idx   (w_arb_idx),
        .o_valid (w_arb_valid)
    );

    // State, grant, counter and round-robin pointer registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_grant  <= {NUM_CLIENTS{1'b0}};
            r_idx    <= {IDXW{1'b0}};
            r_count  <= {CNT_W{1'b0}};
            r_rr_ptr <= {IDXW{1'b0}};
        end else begin
            r_state  <= w_state_nxt;
            r_grant  <= w_grant_nxt;
            r_idx    <= w_idx_nxt;
            r_count  <= w_count_nxt;
            r_rr_ptr <= w_rr_nxt;
        end
    end

    // Next-state logic; ep_reset aborts ahead of anything the clients do.
    always_comb begin
        w_fill      = (r_state == ST_FILL);
        w_wait      = (r_state == ST_WAIT_ACK);
        w_put_g     = bus.client_data_put[r_idx];
        w_done_g    = bus.client_data_done[r_idx];
        w_stall_g   = bus.client_stall[r_idx];
        w_fwd       = w_fill && w_put_g && bus.in_ep_data_free;
        w_count_inc = r_count + 7'd1;
        if (r_idx == LAST_IDX) begin
            w_next_ptr = {IDXW{1'b0}};
        end else begin
            w_next_ptr = r_idx + IDXW'(1);
        end

        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_idx_nxt   = r_idx;
        w_count_nxt = r_count;
        w_rr_nxt    = r_rr_ptr;

        if (bus.ep_reset) begin
            w_state_nxt = ST_IDLE;
            w_grant_nxt = {NUM_CLIENTS{1'b0}};
            w_count_nxt = {CNT_W{1'b0}};
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_arb_valid) begin
                        w_state_nxt = ST_FILL;
                        w_grant_nxt = w_arb_grant;
                        w_idx_nxt   = w_arb_idx;
                        w_count_nxt = {CNT_W{1'b0}};
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_FILL: begin
                    if (w_stall_g) begin
                        w_state_nxt = ST_IDLE;
                        w_grant_nxt = {NUM_CLIENTS{1'b0}};
                        w_rr_nxt    = w_next_ptr;
                    end else begin
                        if (w_fwd) begin
                            w_count_nxt = w_count_inc;
                        end else begin
                            w_count_nxt = r_count;
                        end
                        // A done together with a put still counts that byte before closing.
                        if ((w_fwd && (w_count_inc == MAX_CNT)) || w_done_g) begin
                            w_state_nxt = ST_WAIT_ACK;
                        end else begin
                            w_state_nxt = ST_FILL;
                        end
                    end
                end
                ST_WAIT_ACK: begin
                    if (w_stall_g || bus.in_ep_acked) begin
                        w_state_nxt = ST_IDLE;
                        w_grant_nxt = {NUM_CLIENTS{1'b0}};
                        w_rr_nxt    = w_next_ptr;
                    end else begin
                        w_state_nxt = ST_WAIT_ACK;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_grant_nxt = {NUM_CLIENTS{1'b0}};
                    w_count_nxt = {CNT_W{1'b0}};
                end
            endcase
        end
    end

    assign bus.client_grant = r_grant;

    // Pass-through outputs, forced quiet while reset is held.
    always_comb begin
        bus.client_free     = 1'b0;
        bus.in_ep_data_put  = 1'b0;
        bus.in_ep_data      = 8'd0;
        bus.in_ep_data_done = 1'b0;
        bus.in_ep_stall     = 1'b0;
        bus.client_acked    = {NUM_CLIENTS{1'b0}};
        if (reset) begin
            bus.client_free = 1'b0;
        end else begin
            bus.client_free     = w_fill && bus.in_ep_data_free;
            bus.in_ep_data_put  = w_fwd;
            bus.in_ep_data      = w_fill ? bus.client_data[{r_idx, 3'b000} +: 8] : 8'd0;
            bus.in_ep_data_done = w_fill && w_done_g;
            bus.in_ep_stall     = (w_fill || w_wait) && w_stall_g;
            if (w_wait && bus.in_ep_acked && !bus.ep_reset && !w_stall_g) begin
                bus.client_acked = r_grant;
            end else begin
                bus.client_acked = {NUM_CLIENTS{1'b0}};
            end
        end
    end

endmodule

// File: tb/tb_usb_fs_in_arb.sv
// Bench for usb_fs_in_arb: directed scenarios with literal expectations, then random traffic
// checked every cycle against a transaction-level model.
module tb_usb_fs_in_arb;

    localparam int N   = 4;
    localparam int MAX = 32;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    usb_fs_in_arb_if #(.NUM_CLIENTS(N)) bus ();

    usb_fs_in_arb #(.NUM_CLIENTS(N), .MAX_PKT(MAX)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Model: phase 0 = no transaction, 1 = collecting bytes, 2 = packet closed awaiting ack.
    logic m_known = 1'b0;
    int   m_phase = 0;
    int   m_owner = 0;
    int   m_count = 0;
    int   m_rr    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model advance on each rising edge.
    always @(posedge clk) begin : model_upd
        int ph, own, cnt, rr;
        ph  = m_phase;
        own = m_owner;
        cnt = m_count;
        rr  = m_rr;
        if (reset) begin
            ph = 0; cnt = 0; rr = 0;
        end else if (bus.ep_reset) begin
            ph = 0; cnt = 0;
        end else if (ph == 0) begin
            if (bus.client_req != '0) begin
                for (int k = N - 1; k >= 0; k--) begin
                    if (bus.client_req[(rr + k) % N]) own = (rr + k) % N;
                end
                ph  = 1;
                cnt = 0;
            end
        end else if (bus.client_stall[own]) begin
            ph = 0;
            rr = (own + 1) % N;
        end else if (ph == 1) begin
            if (bus.client_data_put[own] && bus.in_ep_data_free) cnt++;
            if (bus.client_data_done[own] || cnt == MAX) ph = 2;
        end else begin
            if (bus.in_ep_acked) begin
                ph = 0;
                rr = (own + 1) % N;
            end
        end
        m_known <= m_known | reset;
        m_phase <= ph;
        m_owner <= own;
        m_count <= cnt;
        m_rr    <= rr;
    end

    // Every-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin : compare
        logic [N-1:0] e_grant, e_acked;
        logic e_fill, e_wait, e_free, e_put, e_done, e_stall;
        if (m_known) begin
            e_fill  = (m_phase == 1);
            e_wait  = (m_phase == 2);
            e_grant = (m_phase != 0) ? N'(1 << m_owner) : '0;
            e_free  = e_fill && bus.in_ep_data_free;
            e_put   = e_fill && bus.client_data_put[m_owner] && bus.in_ep_data_free;
            e_done  = e_fill && bus.client_data_done[m_owner];
            e_stall = (e_fill || e_wait) && bus.client_stall[m_owner];
            e_acked = (e_wait && bus.in_ep_acked && !bus.ep_reset && !bus.client_stall[m_owner])
                      ? N'(1 << m_owner) : '0;
            if (reset) begin
                e_free = 1'b0; e_put = 1'b0; e_done = 1'b0; e_stall = 1'b0; e_acked = '0;
            end
            check("grant", 32'(bus.client_grant), 32'(e_grant));
            check("acked", 32'(bus.client_acked), 32'(e_acked));
            check("free", 32'(bus.client_free), 32'(e_free));
            check("put", 32'(bus.in_ep_data_put), 32'(e_put));
            check("done", 32'(bus.in_ep_data_done), 32'(e_done));
            check("stall", 32'(bus.in_ep_stall), 32'(e_stall));
            check("grant_onehot", 32'($countones(bus.client_grant) <= 1), 32'd1);
            if (e_put) check("data", 32'(bus.in_ep_data), 32'(bus.client_data[8*m_owner +: 8]));
        end
    end

    task automatic quiet();
        bus.client_req       = '0;
        bus.client_data_put  = '0;
        bus.client_data      = '0;
        bus.client_data_done = '0;
        bus.client_stall     = '0;
        bus.ep_reset         = 1'b0;
        bus.in_ep_data_free  = 1'b1;
        bus.in_ep_acked      = 1'b0;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    initial begin : stim
        int puts;
        logic [3:0] exp;
        quiet();
        reset = 1'b1;
        nxt(); nxt();
        reset = 1'b0;

        // Client 2 alone: five bytes, done, ack.
        bus.client_req = 4'b0100; at_neg(); check("lit_idle_grant", 32'(bus.client_grant), 32'h0); nxt();
        bus.client_req = 4'b0000;
        puts = 0;
        for (int i = 0; i < 5; i++) begin
            bus.client_data_put = 4'b0100;
            bus.client_data     = {8'h00, 8'(8'hA0 + i), 16'h0000};
            at_neg();
            if (i == 0) check("lit_c2_grant", 32'(bus.client_grant), 32'h4);
            if (bus.in_ep_data_put) puts++;
            check("lit_c2_byte", 32'(bus.in_ep_data), 32'(8'hA0 + i));
            nxt();
        end
        bus.client_data_put = '0; bus.client_data_done = 4'b0100;
        at_neg(); check("lit_c2_done", 32'(bus.in_ep_data_done), 32'h1); nxt();
        check("lit_c2_puts", 32'(puts), 32'd5);
        bus.client_data_done = '0; bus.in_ep_acked = 1'b1;
        at_neg(); check("lit_c2_acked", 32'(bus.client_acked), 32'h4);
        check("lit_wait_free", 32'(bus.client_free), 32'h0); nxt();
        bus.in_ep_acked = 1'b0;

        // Clients 0 and 3 from pointer 3: zero-length packets alternate 3,0,3,0.
        bus.client_req = 4'b1001; at_neg(); check("lit_idle_after_ack", 32'(bus.client_grant), 32'h0); nxt();
        for (int p = 0; p < 4; p++) begin
            exp = (p % 2 == 0) ? 4'b1000 : 4'b0001;
            bus.client_data_done = exp;
            at_neg(); check("lit_alt_grant", 32'(bus.client_grant), 32'(exp)); nxt();
            bus.client_data_done = '0; bus.in_ep_acked = 1'b1;
            at_neg(); check("lit_alt_acked", 32'(bus.client_acked), 32'(exp)); nxt();
            bus.in_ep_acked = 1'b0;
            if (p == 3) bus.client_req = '0;
            at_neg(); nxt();
        end

        // Client 1 fills a full packet; the 33rd byte must not pass.
        bus.client_req = 4'b0010; at_neg(); nxt();
        bus.client_req = '0;
        for (int i = 0; i < MAX; i++) begin
            bus.client_data_put = 4'b0010; bus.client_data = 32'($urandom);
            at_neg(); check("lit_full_put", 32'(bus.in_ep_data_put), 32'h1); nxt();
        end
        at_neg(); check("lit_put33_dropped", 32'(bus.in_ep_data_put), 32'h0);
        check("lit_full_free", 32'(bus.client_free), 32'h0); nxt();
        bus.client_data_put = '0; bus.in_ep_acked = 1'b1;
        at_neg(); check("lit_full_acked", 32'(bus.client_acked), 32'h2); nxt();
        bus.in_ep_acked = 1'b0;

        // Client 2: bytes offered while the engine is busy are dropped and not counted.
        bus.client_req = 4'b0100; at_neg(); nxt();
        bus.client_req = '0;
        for (int i = 0; i < 30; i++) begin
            bus.client_data_put = 4'b0100; at_neg(); nxt();
        end
        bus.in_ep_data_free = 1'b0;
        for (int i = 0; i < 3; i++) begin
            at_neg(); check("lit_busy_put", 32'(bus.in_ep_data_put), 32'h0);
            check("lit_busy_free", 32'(bus.client_free), 32'h0); nxt();
        end
        bus.in_ep_data_free = 1'b1;
        at_neg(); check("lit_still_fill", 32'(bus.client_free), 32'h1); nxt();
        at_neg(); check("lit_last_put", 32'(bus.in_ep_data_put), 32'h1); nxt();
        bus.client_data_put = '0; bus.in_ep_acked = 1'b1;
        at_neg(); check("lit_busy_acked", 32'(bus.client_acked), 32'h4); nxt();
        bus.in_ep_acked = 1'b0;

        // Client 0 stalls; a foreign stall first has no effect.
        bus.client_req = 4'b0001; at_neg(); nxt();
        bus.client_req = '0; bus.client_stall = 4'b1000;
        at_neg(); check("lit_foreign_stall", 32'(bus.in_ep_stall), 32'h0); nxt();
        bus.client_stall = 4'b0001;
        at_neg(); check("lit_own_stall", 32'(bus.in_ep_stall), 32'h1);
        check("lit_stall_noack", 32'(bus.client_acked), 32'h0); nxt();
        bus.client_stall = '0;
        at_neg(); check("lit_stall_release", 32'(bus.client_grant), 32'h0); nxt();

        // Client 1: endpoint reset swallows the ack and keeps the pointer.
        bus.client_req = 4'b0010; at_neg(); nxt();
        bus.client_req = '0; bus.client_data_done = 4'b0010;
        at_neg(); check("lit_c1_grant", 32'(bus.client_grant), 32'h2); nxt();
        bus.client_data_done = '0; bus.ep_reset = 1'b1; bus.in_ep_acked = 1'b1;
        at_neg(); check("lit_epreset_ack", 32'(bus.client_acked), 32'h0); nxt();
        bus.ep_reset = 1'b0; bus.in_ep_acked = 1'b0; bus.client_req = 4'b1111;
        at_neg(); check("lit_epreset_grant", 32'(bus.client_grant), 32'h0); nxt();
        bus.client_req = '0;
        at_neg(); check("lit_rr_kept", 32'(bus.client_grant), 32'h2); nxt();
        bus.ep_reset = 1'b1; nxt();
        bus.ep_reset = 1'b0;

        // Random traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            bus.client_req       = 4'($urandom);
            bus.client_data_put  = 4'($urandom);
            bus.client_data      = 32'($urandom);
            bus.client_data_done = ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'b0000;
            bus.client_stall     = ($urandom_range(0, 31) == 0) ? 4'($urandom) : 4'b0000;
            bus.in_ep_data_free  = ($urandom_range(0, 3) != 0);
            bus.in_ep_acked      = ($urandom_range(0, 3) == 0);
            bus.ep_reset         = ($urandom_range(0, 63) == 0);
            reset                = ($urandom_range(0, 255) == 0);
            nxt();
        end
        reset = 1'b0;
        quiet();
        nxt(); nxt();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
